// File: rtl/time_entry_loader.sv
// Keypad time-entry loader: shifts BCD digits into an M:SS load word and
// issues a one-cycle active-low load strobe, or an error pulse if the seconds-tens digit exceeds 5.
module time_entry_loader (
   input  logic       clk,
   input  logic       clr,
   input  logic       digit_valid,
   input  logic [3:0] digit,
   input  logic       enter,
   input  logic       cancel,
   input  logic       run,
   output logic [3:0] min_u,
   output logic [3:0] sec_t,
   output logic [3:0] sec_u,
   output logic       loadn,
   output logic [1:0] count,
   output logic       err,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, ENTRY, LOAD, ERROR} state_t;

   state_t     state_reg, state_next;
   logic [3:0] min_u_reg, min_u_next;
   logic [3:0] sec_t_reg, sec_t_next;
   logic [3:0] sec_u_reg, sec_u_next;
   logic [1:0] count_reg, count_next;
   logic       loadn_reg, err_reg, busy_reg;

   always_comb begin
      state_next = state_reg;
      min_u_next = min_u_reg;
      sec_t_next = sec_t_reg;
      sec_u_next = sec_u_reg;
      count_next = count_reg;
      case (state_reg)
         IDLE, ENTRY: begin
            if (cancel) begin
               state_next = IDLE;
               min_u_next = 4'd0;
               sec_t_next = 4'd0;
               sec_u_next = 4'd0;
               count_next = 2'd0;
            end else if (!run && enter && state_reg == ENTRY) begin
               // A pending digit is dropped: the commit uses the digits already held.
               state_next = (sec_t_reg <= 4'd5) ? LOAD : ERROR;
            end else if (!run && digit_valid && digit <= 4'd9 && count_reg != 2'd3) begin
               state_next = ENTRY;
               min_u_next = sec_t_reg;
               sec_t_next = sec_u_reg;
               sec_u_next = digit;
               count_next = count_reg + 2'd1;
            end
         end
         default: begin
            // LOAD and ERROR last exactly one cycle and ignore every input.
            state_next = IDLE;
            min_u_next = 4'd0;
            sec_t_next = 4'd0;
            sec_u_next = 4'd0;
            count_next = 2'd0;
         end
      endcase
   end

   // Strobes are decoded from the next state so they register in step with it.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_reg <= IDLE;
         min_u_reg <= 4'd0;
         sec_t_reg <= 4'd0;
         sec_u_reg <= 4'd0;
         count_reg <= 2'd0;
         loadn_reg <= 1'b1;
         err_reg   <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         min_u_reg <= min_u_next;
         sec_t_reg <= sec_t_next;
         sec_u_reg <= sec_u_next;
         count_reg <= count_next;
         loadn_reg <= (state_next != LOAD);
         err_reg   <= (state_next == ERROR);
         busy_reg  <= (state_next == ENTRY) || (state_next == LOAD);
      end
   end

   assign min_u = min_u_reg;
   assign sec_t = sec_t_reg;
   assign sec_u = sec_u_reg;
   assign count = count_reg;
   assign loadn = loadn_reg;
   assign err   = err_reg;
   assign busy  = busy_reg;

endmodule
